alu72: RTL and testbench



---
 rtl/alu72.sv | 55 +++++
 tb/tb_alu72.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu72.sv
// 72-bit registered ALU: one op/operand set accepted per cycle, result in C one edge later.
// Compares yield 0/1 in bit 0; unused or unknown opcodes load zero.
module alu72 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  op,
    input  logic [71:0] A,
    input  logic [71:0] B,
    output logic [71:0] C
);

    logic [71:0] sum;
    logic [71:0] diff;
    logic [71:0] prod;
    logic [71:0] shl;
    logic [71:0] shr;
    logic        eq;
    logic        gt;
    logic        lt;
    logic [71:0] result;

    assign sum  = A + B;
    assign diff = A - B;
    // Only the low half of the full product is kept.
    assign prod = A * B;
    assign shl  = {A[70:0], 1'b0};
    assign shr  = {1'b0, A[71:1]};
    assign eq   = (A == B);
    assign gt   = (A > B);
    assign lt   = (A < B);

    always_comb begin
        result = 72'h0;
        case (op)
            4'd0:    result = sum;
            4'd1:    result = diff;
            4'd2:    result = prod;
            4'd3:    result = shl;
            4'd4:    result = shr;
            4'd5:    result = {71'h0, eq};
            4'd6:    result = {71'h0, gt};
            4'd7:    result = {71'h0, lt};
            default: result = 72'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C <= 72'h0;
        end else begin
            C <= result;
        end
    end

endmodule

// File: tb/tb_alu72.sv
// Self-checking bench for alu72: directed corner cases, reset behaviour and a random
// back-to-back run compared against an arithmetic reference model.
module tb_alu72;

    logic        clk;
    logic        rst_n;
    logic [3:0]  op;
    logic [71:0] A;
    logic [71:0] B;
    logic [71:0] C;

    int checks;
    int failures;

    localparam logic [71:0] ALL_ONES = {72{1'b1}};
    localparam logic [71:0] TOP_BIT  = 72'h800000000000000000;

    alu72 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (op),
        .A     (A),
        .B     (B),
        .C     (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] model(input logic [3:0] o, input logic [71:0] a,
                                          input logic [71:0] b);
        logic [143:0] full;
        if ($isunknown(o)) return 72'h0;
        case (o)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: begin
                full = {72'h0, a} * {72'h0, b};
                return full[71:0];
            end
            4'd3: return a * 2;
            4'd4: return a / 2;
            4'd5: return (a == b) ? 72'd1 : 72'd0;
            4'd6: return (a > b) ? 72'd1 : 72'd0;
            4'd7: return (a < b) ? 72'd1 : 72'd0;
            default: return 72'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [71:0] expected);
        checks++;
        assert (C === expected) else begin
            failures++;
            $error("FAIL %s: C=%h expected %h", tag, C, expected);
        end
    endtask

    // Drive one operation between edges, then check the result just after the next edge.
    task automatic step(input logic [3:0] o, input logic [71:0] a, input logic [71:0] b,
                        input string tag);
        logic [71:0] expected;
        @(negedge clk);
        op = o;
        A  = a;
        B  = b;
        expected = model(o, a, b);
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    function automatic logic [71:0] rand72();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[71:0];
    endfunction

    initial begin
        logic [71:0] ra;
        logic [71:0] rb;
        logic [3:0]  ro;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        op       = 4'd0;
        A        = 72'd1;
        B        = 72'd1;

        #1;
        check("reset_value", 72'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_holds_over_edges", 72'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step(4'd0, 72'd1, 72'd1, "add_1_1");
        step(4'd0, ALL_ONES, 72'd1, "add_wrap");
        step(4'd1, 72'h10, 72'h5, "sub_10_5");
        step(4'd1, 72'd0, 72'd1, "sub_wrap");
        step(4'd2, 72'd3, 72'd2, "mul_3_2");
        step(4'd2, TOP_BIT, 72'd2, "mul_trunc");
        step(4'd3, 72'd1, 72'h0, "shl_1");
        step(4'd3, TOP_BIT, ALL_ONES, "shl_msb_out");
        step(4'd4, 72'h10, 72'h0, "shr_10");
        step(4'd4, ALL_ONES, 72'h0, "shr_msb_zero");
        step(4'd5, 72'd1, 72'd1, "eq_true");
        step(4'd5, 72'd1, 72'd2, "eq_false");
        step(4'd6, 72'h10, 72'd5, "gt_true");
        step(4'd6, 72'd5, 72'h10, "gt_swapped");
        step(4'd7, 72'd5, 72'h10, "lt_true");
        step(4'd7, 72'h10, 72'd5, "lt_swapped");
        step(4'd9, 72'd1, 72'd1, "op_9_zero");
        step(4'd15, ALL_ONES, ALL_ONES, "op_15_zero");
        step(4'b1xxx, 72'd1, 72'd1, "op_1xxx_zero");
        step(4'bxxxx, 72'd1, 72'd1, "op_x_zero");

        // Asynchronous reset between edges with a nonzero result held.
        step(4'd0, 72'd5, 72'd6, "pre_reset_add");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clears", 72'h0);
        @(negedge clk);
        op = 4'd0;
        A  = 72'd7;
        B  = 72'd7;
        @(posedge clk);
        #1;
        check("reset_discards_edge", 72'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check("zero_after_release", 72'h0);
        step(4'd0, 72'd1, 72'd1, "first_edge_after_release");

        // Random back-to-back traffic, with equal operands forced now and then.
        for (int i = 0; i < 300; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = rand72();
            rb = ($urandom_range(0, 3) == 0) ? ra : rand72();
            if ($urandom_range(0, 7) == 0) rb = 72'($urandom_range(0, 3));
            step(ro, ra, rb, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
